// File: rtl/fir_lpf_ntap.sv
// fir_lpf_ntap: N-tap unsigned low-pass FIR with valid-qualified samples.
// Three-stage pipeline (tap line, products, round/saturate) with a bypass
// path that travels alongside each sample so mode changes never reorder
// or drop outputs.
// Optional macro FIR_COEF_WR_EN: adds a runtime coefficient write port;
// without it the coefficients are the constants in COEF_INIT.
module fir_lpf_ntap #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 3,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 8,
    parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {8'd64, 8'd128, 8'd64}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     fir_bypass,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        din,
`ifdef FIR_COEF_WR_EN
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
`endif
    output logic                     out_valid,
    output logic [DATA_W-1:0]        dout
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    // One spare bit so the rounding constant can never carry out.
    localparam int SUM_W  = ACC_W + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [SUM_W-1:0] RND = (SHIFT > 0) ? (SUM_W'(1) << RND_POS) : '0;
    localparam logic [SUM_W-1:0] MAX_OUT = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic [DATA_W-1:0] tap  [TAPS];
    logic [COEF_W-1:0] coef [TAPS];
    logic [PROD_W-1:0] prod [TAPS];
    logic              v1, v2;
    logic              byp1, byp2;
    logic [DATA_W-1:0] raw2;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  scaled;
    logic [DATA_W-1:0] sat;

`ifdef FIR_COEF_WR_EN
    // Coefficient bank: reset image plus runtime writes; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) coef[k] <= COEF_INIT[k*COEF_W +: COEF_W];
        end else if (coef_we && (int'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_wdata;
        end
    end
`else
    // Fixed coefficients unpacked from the parameter image.
    always_comb begin
        for (int k = 0; k < TAPS; k++) coef[k] = COEF_INIT[k*COEF_W +: COEF_W];
    end
`endif

    // S1: tap line shifts on accepted samples; clr wipes history and drops the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) tap[k] <= '0;
            v1   <= 1'b0;
            byp1 <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < TAPS; k++) tap[k] <= '0;
            v1   <= 1'b0;
            byp1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                tap[0] <= din;
                for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
                byp1 <= fir_bypass;
            end
        end
    end

    // S2: per-tap products; the raw sample rides along for the bypass path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) prod[k] <= '0;
            v2   <= 1'b0;
            byp2 <= 1'b0;
            raw2 <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++)
                prod[k] <= {{COEF_W{1'b0}}, tap[k]} * {{DATA_W{1'b0}}, coef[k]};
            v2   <= v1 & ~clr;
            byp2 <= byp1;
            raw2 <= tap[0];
        end
    end

    // Accumulate, round to nearest (half up), normalise and clamp.
    always_comb begin
        sum = RND;
        for (int k = 0; k < TAPS; k++)
            sum = sum + {{(SUM_W-PROD_W){1'b0}}, prod[k]};
        scaled = sum >> SHIFT;
        sat    = (scaled > MAX_OUT) ? {DATA_W{1'b1}} : scaled[DATA_W-1:0];
    end

    // S3: output register; dout only moves when a sample emerges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) dout <= byp2 ? raw2 : sat;
        end
    end

endmodule
